// File: rtl/fft_controller.sv
// Radix-2 DIT FFT sequencer: bit-reversed load, in-place butterfly passes, magnitude readout.
// Optional FFT_CONTROLLER_STAGE_SCALE_EN halves every butterfly output component before write-back.
module fft_controller #(
  parameter  int FFT_POINTS      = 512,
  parameter  int DATA_WIDTH      = 24,
  parameter  int TWIDDLE_WIDTH   = 24,
  localparam int LOG2_FFT_POINTS = $clog2(FFT_POINTS)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         i_data_ready,
  output logic [LOG2_FFT_POINTS-1:0]   o_buffer_read_addr,
  input  logic [DATA_WIDTH-1:0]        i_buffer_data_in,
  output logic [LOG2_FFT_POINTS-1:0]   o_ram_addr_a,
  output logic [LOG2_FFT_POINTS-1:0]   o_ram_addr_b,
  output logic [2*DATA_WIDTH-1:0]      o_ram_data_in_a,
  output logic [2*DATA_WIDTH-1:0]      o_ram_data_in_b,
  output logic                         o_ram_wr_en_a,
  output logic                         o_ram_wr_en_b,
  input  logic [2*DATA_WIDTH-1:0]      i_ram_data_out_a,
  input  logic [2*DATA_WIDTH-1:0]      i_ram_data_out_b,
  output logic [LOG2_FFT_POINTS-1:0]   o_twiddle_addr,
  input  logic [2*TWIDDLE_WIDTH-1:0]   i_twiddle_factor,
  output logic                         o_butterfly_start,
  input  logic                         i_butterfly_valid,
  input  logic [2*DATA_WIDTH-1:0]      i_butterfly_a_out,
  input  logic [2*DATA_WIDTH-1:0]      i_butterfly_b_out,
  output logic                         o_magnitude_start,
  input  logic                         i_magnitude_valid,
  input  logic [DATA_WIDTH-1:0]        i_magnitude_in,
  output logic [DATA_WIDTH-1:0]        o_magnitude_out,
  output logic                         o_fft_busy,
  output logic                         o_fft_done
);

  localparam int LW = LOG2_FFT_POINTS;
  localparam int SW = $clog2(LOG2_FFT_POINTS + 1);
  localparam logic [LW-1:0] LAST_IDX   = LW'(FFT_POINTS - 1);
  localparam logic [LW-1:0] LAST_BF    = LW'(FFT_POINTS / 2 - 1);
  localparam logic [SW-1:0] LAST_STAGE = SW'(LW - 1);

  typedef enum logic [3:0] {
    IDLE, LOAD, BF_ADDR, BF_START, BF_WAIT, BF_WRITE,
    MAG_ADDR, MAG_START, MAG_WAIT, DONE
  } state_t;

  state_t                  state, state_nxt;
  logic [LW-1:0]           idx;
  logic [SW-1:0]           stage;
  logic [2*DATA_WIDTH-1:0] bf_a_q, bf_b_q;

  // Twiddle ROM and RAM read data go straight to the external butterfly/magnitude units.
  logic unused_inputs;
  assign unused_inputs = ^{i_twiddle_factor, i_ram_data_out_a, i_ram_data_out_b};

  function automatic logic [2*DATA_WIDTH-1:0] scale(input logic [2*DATA_WIDTH-1:0] w);
`ifdef FFT_CONTROLLER_STAGE_SCALE_EN
    logic signed [DATA_WIDTH-1:0] re, im;
    re = w[2*DATA_WIDTH-1:DATA_WIDTH];
    im = w[DATA_WIDTH-1:0];
    return {re >>> 1, im >>> 1};
`else
    return w;
`endif
  endfunction

  logic [LW-1:0] span_mask, bf_addr_a, bf_addr_b, tw_addr, load_addr;

  // idx doubles as load index i, butterfly index j and magnitude index k.
  always_comb begin
    span_mask = (LW'(1) << stage) - LW'(1);
    bf_addr_a = ((idx >> stage) << (stage + SW'(1))) | (idx & span_mask);
    bf_addr_b = bf_addr_a + (LW'(1) << stage);
    tw_addr   = (idx & span_mask) << (LAST_STAGE - stage);
    load_addr = '0;
    for (int b = 0; b < LW; b++) load_addr[b] = idx[LW-1-b];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      idx             <= '0;
      stage           <= '0;
      bf_a_q          <= '0;
      bf_b_q          <= '0;
      o_magnitude_out <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          idx   <= '0;
          stage <= '0;
        end
        LOAD: begin
          idx   <= (idx == LAST_IDX) ? '0 : idx + LW'(1);
          stage <= '0;
        end
        BF_WAIT: begin
          if (i_butterfly_valid) begin
            bf_a_q <= i_butterfly_a_out;
            bf_b_q <= i_butterfly_b_out;
          end
        end
        BF_WRITE: begin
          if (idx == LAST_BF) begin
            idx   <= '0;
            stage <= (stage == LAST_STAGE) ? '0 : stage + SW'(1);
          end else begin
            idx <= idx + LW'(1);
          end
        end
        MAG_WAIT: begin
          if (i_magnitude_valid) begin
            o_magnitude_out <= i_magnitude_in;
            idx             <= (idx == LAST_IDX) ? '0 : idx + LW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt          = state;
    o_buffer_read_addr = '0;
    o_ram_addr_a       = '0;
    o_ram_addr_b       = '0;
    o_ram_data_in_a    = '0;
    o_ram_data_in_b    = '0;
    o_ram_wr_en_a      = 1'b0;
    o_ram_wr_en_b      = 1'b0;
    o_twiddle_addr     = '0;
    o_butterfly_start  = 1'b0;
    o_magnitude_start  = 1'b0;
    o_fft_busy         = (state != IDLE);
    o_fft_done         = (state == DONE);
    case (state)
      IDLE: if (i_data_ready) state_nxt = LOAD;
      LOAD: begin
        o_buffer_read_addr = idx;
        o_ram_addr_a       = load_addr;
        o_ram_data_in_a    = {i_buffer_data_in, {DATA_WIDTH{1'b0}}};
        o_ram_wr_en_a      = 1'b1;
        if (idx == LAST_IDX) state_nxt = BF_ADDR;
      end
      BF_ADDR, BF_START, BF_WAIT, BF_WRITE: begin
        o_ram_addr_a   = bf_addr_a;
        o_ram_addr_b   = bf_addr_b;
        o_twiddle_addr = tw_addr;
        if (state == BF_ADDR) state_nxt = BF_START;
        if (state == BF_START) begin
          o_butterfly_start = 1'b1;
          state_nxt         = BF_WAIT;
        end
        if (state == BF_WAIT && i_butterfly_valid) state_nxt = BF_WRITE;
        if (state == BF_WRITE) begin
          o_ram_data_in_a = scale(bf_a_q);
          o_ram_data_in_b = scale(bf_b_q);
          o_ram_wr_en_a   = 1'b1;
          o_ram_wr_en_b   = 1'b1;
          state_nxt = (idx == LAST_BF && stage == LAST_STAGE) ? MAG_ADDR : BF_ADDR;
        end
      end
      MAG_ADDR, MAG_START, MAG_WAIT: begin
        o_ram_addr_a = idx;
        if (state == MAG_ADDR) state_nxt = MAG_START;
        if (state == MAG_START) begin
          o_magnitude_start = 1'b1;
          state_nxt         = MAG_WAIT;
        end
        if (state == MAG_WAIT && i_magnitude_valid)
          state_nxt = (idx == LAST_IDX) ? DONE : MAG_ADDR;
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fft_controller.sv
// Directed bench for fft_controller with RAM, add/sub butterfly and pass-through magnitude models.
module tb_fft_controller;
  localparam int N  = 512;
  localparam int W  = 24;
  localparam int TW = 24;
  localparam int LW = 9;

  logic            clk = 1'b0;
  logic            reset;
  logic            i_data_ready;
  logic [LW-1:0]   o_buffer_read_addr;
  logic [W-1:0]    i_buffer_data_in;
  logic [LW-1:0]   o_ram_addr_a, o_ram_addr_b;
  logic [2*W-1:0]  o_ram_data_in_a, o_ram_data_in_b;
  logic            o_ram_wr_en_a, o_ram_wr_en_b;
  logic [2*W-1:0]  i_ram_data_out_a = '0, i_ram_data_out_b = '0;
  logic [LW-1:0]   o_twiddle_addr;
  logic [2*TW-1:0] i_twiddle_factor = '0;
  logic            o_butterfly_start;
  logic            i_butterfly_valid;
  logic [2*W-1:0]  i_butterfly_a_out = '0, i_butterfly_b_out = '0;
  logic            o_magnitude_start;
  logic            i_magnitude_valid;
  logic [W-1:0]    i_magnitude_in = '0;
  logic [W-1:0]    o_magnitude_out;
  logic            o_fft_busy, o_fft_done;

  fft_controller dut (
    .clk(clk), .reset(reset), .i_data_ready(i_data_ready),
    .o_buffer_read_addr(o_buffer_read_addr), .i_buffer_data_in(i_buffer_data_in),
    .o_ram_addr_a(o_ram_addr_a), .o_ram_addr_b(o_ram_addr_b),
    .o_ram_data_in_a(o_ram_data_in_a), .o_ram_data_in_b(o_ram_data_in_b),
    .o_ram_wr_en_a(o_ram_wr_en_a), .o_ram_wr_en_b(o_ram_wr_en_b),
    .i_ram_data_out_a(i_ram_data_out_a), .i_ram_data_out_b(i_ram_data_out_b),
    .o_twiddle_addr(o_twiddle_addr), .i_twiddle_factor(i_twiddle_factor),
    .o_butterfly_start(o_butterfly_start), .i_butterfly_valid(i_butterfly_valid),
    .i_butterfly_a_out(i_butterfly_a_out), .i_butterfly_b_out(i_butterfly_b_out),
    .o_magnitude_start(o_magnitude_start), .i_magnitude_valid(i_magnitude_valid),
    .i_magnitude_in(i_magnitude_in), .o_magnitude_out(o_magnitude_out),
    .o_fft_busy(o_fft_busy), .o_fft_done(o_fft_done)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Input buffer holds addr+1; RAM reads one cycle late; twiddle ROM is a registered echo.
  assign i_buffer_data_in = W'(o_buffer_read_addr) + W'(1);
  logic [2*W-1:0] mem [N];
  int bf_cnt  = 0;
  int mag_cnt = 0;
  assign i_butterfly_valid = (bf_cnt == 1);
  assign i_magnitude_valid = (mag_cnt == 1);

  always @(posedge clk) begin
    if (o_ram_wr_en_a) mem[o_ram_addr_a] <= o_ram_data_in_a;
    if (o_ram_wr_en_b) mem[o_ram_addr_b] <= o_ram_data_in_b;
    i_ram_data_out_a <= mem[o_ram_addr_a];
    i_ram_data_out_b <= mem[o_ram_addr_b];
    i_twiddle_factor <= {TW'(o_twiddle_addr), {TW{1'b0}}};
    // Butterfly a+b / a-b per component, valid on the third cycle counting the start cycle.
    if (o_butterfly_start) begin
      bf_cnt <= 2;
      i_butterfly_a_out <= {i_ram_data_out_a[2*W-1:W] + i_ram_data_out_b[2*W-1:W],
                            i_ram_data_out_a[W-1:0]   + i_ram_data_out_b[W-1:0]};
      i_butterfly_b_out <= {i_ram_data_out_a[2*W-1:W] - i_ram_data_out_b[2*W-1:W],
                            i_ram_data_out_a[W-1:0]   - i_ram_data_out_b[W-1:0]};
    end else if (bf_cnt != 0) begin
      bf_cnt <= bf_cnt - 1;
    end
    if (o_magnitude_start) begin
      mag_cnt <= 1;
      i_magnitude_in <= i_ram_data_out_a[2*W-1:W];
    end else if (mag_cnt != 0) begin
      mag_cnt <= mag_cnt - 1;
    end
  end

  int ncyc = 0, bf_starts = 0, last_bf_cyc = 0, max_gap = 0;
  int mag_starts = 0, done_cnt = 0, mag_idx = 0;
  bit mag_flag = 1'b0, first_wr_seen = 1'b0;
  logic [LW-1:0]  cap_a [3], cap_b [3], cap_tw [3];
  logic [LW-1:0]  first_wr_addr_a, first_wr_addr_b;
  logic [2*W-1:0] first_wr_a, first_wr_b;
  logic [W-1:0]   mags [N];

  always @(negedge clk) begin
    ncyc++;
    if (o_butterfly_start) begin
      if (bf_starts > 0 && bf_starts < N / 2 * LW && ncyc - last_bf_cyc > max_gap)
        max_gap = ncyc - last_bf_cyc;
      last_bf_cyc = ncyc;
      if (bf_starts == 0)    begin cap_a[0] = o_ram_addr_a; cap_b[0] = o_ram_addr_b; cap_tw[0] = o_twiddle_addr; end
      if (bf_starts == 259)  begin cap_a[1] = o_ram_addr_a; cap_b[1] = o_ram_addr_b; cap_tw[1] = o_twiddle_addr; end
      if (bf_starts == 2053) begin cap_a[2] = o_ram_addr_a; cap_b[2] = o_ram_addr_b; cap_tw[2] = o_twiddle_addr; end
      bf_starts++;
    end
    if (o_ram_wr_en_b && !first_wr_seen) begin
      first_wr_seen   = 1'b1;
      first_wr_addr_a = o_ram_addr_a;
      first_wr_addr_b = o_ram_addr_b;
      first_wr_a      = o_ram_data_in_a;
      first_wr_b      = o_ram_data_in_b;
    end
    if (o_magnitude_start) mag_starts++;
    if (o_fft_done) done_cnt++;
    if (mag_flag) begin
      if (mag_idx < N) mags[mag_idx] = o_magnitude_out;
      mag_idx++;
    end
    mag_flag = i_magnitude_valid;
  end

  initial begin
    bit   seen;
    time  t0;
    int   elapsed;
    reset = 1'b0;
    i_data_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy",      o_fft_busy, 0);
    check("rst_done",      o_fft_done, 0);
    check("rst_wr_en",     {o_ram_wr_en_a, o_ram_wr_en_b}, 0);
    check("rst_addrs",     {o_buffer_read_addr, o_ram_addr_a, o_ram_addr_b, o_twiddle_addr}, 0);
    check("rst_starts",    {o_butterfly_start, o_magnitude_start}, 0);
    check("rst_mag_out",   o_magnitude_out, 0);

    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_wait_busy", o_fft_busy, 0);

    t0 = $time;
    i_data_ready = 1'b1;
    @(negedge clk);
    i_data_ready = 1'b0;
    check("start_busy",     o_fft_busy, 1);
    check("load0_buf_addr", o_buffer_read_addr, 0);
    check("load0_ram_addr", o_ram_addr_a, 0);
    check("load0_wr",       {o_ram_wr_en_a, o_ram_wr_en_b}, 2'b10);
    check("load0_data",     o_ram_data_in_a, 48'h000001_000000);
    @(negedge clk);
    check("load1_ram_addr", o_ram_addr_a, 256);
    check("load1_data",     o_ram_data_in_a, 48'h000002_000000);

    seen = 1'b0;
    for (int c = 0; c < 1000 && !seen; c++) begin
      @(negedge clk);
      if (o_butterfly_start) seen = 1'b1;
    end
    check("first_bf_start_seen", seen, 1);
    check("ram256", mem[256], 48'h000002_000000);
    check("ram1",   mem[1],   48'h000101_000000);
    check("ram511", mem[511], 48'h000200_000000);

    // Start request while busy must not cause a second run.
    i_data_ready = 1'b1;
    @(negedge clk);
    i_data_ready = 1'b0;

    seen = 1'b0;
    for (int c = 0; c < 20000 && !seen; c++) begin
      @(negedge clk);
      if (o_fft_done) seen = 1'b1;
    end
    elapsed = int'(($time - t0) / 10);
    check("done_seen",        seen, 1);
    check("done_busy_high",   o_fft_busy, 1);
    check("run_within_20000", elapsed < 20000, 1);
    @(negedge clk);
    check("done_one_cycle",   o_fft_done, 0);
    check("busy_falls",       o_fft_busy, 0);
    repeat (6) @(negedge clk);
    check("done_count",       done_cnt, 1);
    check("bf_start_count",   bf_starts, 2304);
    check("mag_start_count",  mag_starts, 512);
    check("bf_gap_cycles",    max_gap, 5);
    check("s0j0_addrs",       {cap_a[0], cap_b[0], cap_tw[0]}, {9'd0, 9'd1, 9'd0});
    check("s1j3_addrs",       {cap_a[1], cap_b[1], cap_tw[1]}, {9'd5, 9'd7, 9'd128});
    check("s8j5_addrs",       {cap_a[2], cap_b[2], cap_tw[2]}, {9'd5, 9'd261, 9'd5});
    check("first_wr_addrs",   {first_wr_addr_a, first_wr_addr_b}, {9'd0, 9'd1});
    check("first_wr_a",       first_wr_a, 48'h000102_000000);
    check("first_wr_b",       first_wr_b, 48'hFFFF00_000000);
    check("mag_count",        mag_idx, 512);
    check("mag0",             mags[0], 24'h020100);
    check("mag1",             mags[1], 24'hFF0000);
    check("mag511",           mags[511], 24'h000000);

    // Second run, abandoned by reset in the middle of stage 4.
    i_data_ready = 1'b1;
    @(negedge clk);
    i_data_ready = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10000 && !seen; c++) begin
      @(negedge clk);
      if (bf_starts >= 2304 + 4 * 256 + 10) seen = 1'b1;
    end
    check("reached_stage4", seen, 1);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("midrst_busy",  o_fft_busy, 0);
    check("midrst_addrs", {o_ram_addr_a, o_ram_addr_b, o_twiddle_addr, o_buffer_read_addr}, 0);
    check("midrst_ctrl",  {o_ram_wr_en_a, o_ram_wr_en_b, o_butterfly_start, o_magnitude_start, o_fft_done}, 0);
    check("midrst_data",  {o_ram_data_in_a, o_magnitude_out}, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("postrst_idle", o_fft_busy, 0);
    i_data_ready = 1'b1;
    @(negedge clk);
    i_data_ready = 1'b0;
    check("restart_busy",     o_fft_busy, 1);
    check("restart_buf_addr", o_buffer_read_addr, 0);
    check("restart_wr",       {o_ram_wr_en_a, o_ram_addr_a}, {1'b1, 9'd0});
    @(negedge clk);
    check("restart_load1",    {o_buffer_read_addr, o_ram_addr_a}, {9'd1, 9'd256});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
